// File: rtl/cpu_controller_pkg.sv
// cpu_defs: encodings shared by the sequencing controller and the datapath.
//   - opcode / opext field values for every defined instruction
//   - write-back source select codes
//   - controller state encoding and decoded instruction classes
package cpu_defs;

  localparam logic [3:0] OPC_ALU  = 4'b0000;
  localparam logic [3:0] OPC_MEM  = 4'b0100;

  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  localparam logic [15:0] INSTR_HALT = 16'h0000;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // CLS_ALU_FLAG covers the ALU ops that update flags and write back.
  typedef enum logic [2:0] {
    CLS_ALU      = 3'd0,
    CLS_ALU_FLAG = 3'd1,
    CLS_CMP      = 3'd2,
    CLS_LOAD     = 3'd3,
    CLS_STOR     = 3'd4,
    CLS_HALT     = 3'd5,
    CLS_ILLEGAL  = 3'd6
  } iclass_t;

endpackage

// File: rtl/cpu_controller_decode.sv
// instr_decode: purely combinational classification of an instruction word.
// Ports:
//   instr   in  16  instruction word (opcode[15:12] rdest[11:8] opext[7:4] rsrc[3:0])
//   iclass  out     decoded instruction class
//   illegal out  1  word is not a defined encoding
module instr_decode
  import cpu_defs::*;
(
  input  logic [15:0] instr,
  output iclass_t     iclass,
  output logic        illegal
);

  always_comb begin
    iclass = CLS_ILLEGAL;
    if (instr == INSTR_HALT) begin
      iclass = CLS_HALT;
    end else if (instr[15:12] == OPC_ALU) begin
      case (instr[7:4])
        EXT_ADD, EXT_SUB:                   iclass = CLS_ALU_FLAG;
        EXT_MOV, EXT_AND, EXT_OR, EXT_XOR:  iclass = CLS_ALU;
        EXT_CMP:                            iclass = CLS_CMP;
        default:                            iclass = CLS_ILLEGAL;
      endcase
    end else if (instr[15:12] == OPC_MEM) begin
      case (instr[7:4])
        EXT_LOAD: iclass = CLS_LOAD;
        EXT_STOR: iclass = CLS_STOR;
        default:  iclass = CLS_ILLEGAL;
      endcase
    end
  end

  assign illegal = (iclass == CLS_ILLEGAL);

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle instruction sequencer.
// Ports:
//   clk, rst (async, active low)
//   instr/instr_valid/instr_ready  instruction fetch handshake
//   mem_req/mem_we/mem_ack         data memory access
//   alu_op, rdest_sel, rsrc_sel    latched instruction fields
//   reg_we, wb_sel, flag_we        datapath strobes
//   halted, illegal, mem_err       status
//   retired                        completed-instruction count (wraps)
//
// state  | meaning
// -------+----------------------------------------------------------
// FETCH  | instr_ready=1, latch word when instr_valid
// DECODE | classify latched word; illegal pulses and retires here
// EXEC   | ALU cycle; flag_we for ADD/SUB/CMP; CMP retires here
// MEM    | mem_req held until mem_ack or timeout; STOR/timeout retire
// WB     | reg_we one cycle, wb_sel from instruction class
// HALT   | halted=1, inputs ignored until reset
module cpu_controller
  import cpu_defs::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       alu_op,
  output logic [3:0]       rdest_sel,
  output logic [3:0]       rsrc_sel,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             flag_we,
  output logic             halted,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  iclass_t          iclass;
  logic             dec_illegal;

  // Decode always looks at the latched word, which is stable from DECODE
  // until the next FETCH latch, so later states can reuse the class.
  instr_decode u_decode (
    .instr   (instr_q),
    .iclass  (iclass),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      instr_q   <= '0;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    tmo_d       = tmo_q;
    mem_err_d   = mem_err_q;
    retired_d   = retired_q;
    retire      = 1'b0;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_SEL_ALU;
    flag_we     = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        illegal = dec_illegal;
        case (iclass)
          CLS_HALT: state_d = ST_HALT;
          CLS_ILLEGAL: begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STOR: begin
            tmo_d   = TMO_LOAD;
            state_d = ST_MEM;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        flag_we = (iclass == CLS_ALU_FLAG) || (iclass == CLS_CMP);
        if (iclass == CLS_CMP) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (iclass == CLS_STOR);
        if (mem_ack) begin
          tmo_d = '0;
          if (iclass == CLS_STOR) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_q == '0) begin
          // Terminal count reached without an ack: abandon the access.
          mem_err_d = 1'b1;
          retire    = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (iclass == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    if (retire) retired_d = retired_q + CNT_W'(1);
  end

  assign alu_op    = instr_q[7:4];
  assign rdest_sel = instr_q[11:8];
  assign rsrc_sel  = instr_q[3:0];
  assign mem_err   = mem_err_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus pushes expected events into
// per-kind queues, a negedge monitor pops and compares as the DUT emits them.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instr_valid = 1'b0;
  logic        mem_ack = 1'b0;
  logic        instr_ready, mem_req, mem_we, reg_we, wb_sel, flag_we;
  logic        halted, illegal, mem_err;
  logic [3:0]  alu_op, rdest_sel, rsrc_sel;
  logic [15:0] retired;

  cpu_controller #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .alu_op(alu_op), .rdest_sel(rdest_sel),
    .rsrc_sel(rsrc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .flag_we(flag_we), .halted(halted), .illegal(illegal),
    .mem_err(mem_err), .retired(retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic wb_sel; logic [3:0] rdest; logic [3:0] rsrc; logic [3:0] alu_op; } reg_exp_t;
  typedef struct { int cyc; int val; } ret_exp_t;
  typedef struct { int len; logic we; } mem_exp_t;

  reg_exp_t q_reg[$];
  ret_exp_t q_ret[$];
  mem_exp_t q_mem[$];
  int       q_flag[$];
  int       q_ill[$];

  reg_exp_t re;
  ret_exp_t rt;
  mem_exp_t me;
  int       ce;
  int       mem_run = 0;
  logic     mem_we_first = 1'b0;
  int       prev_ret = 0;

  always @(negedge clk) begin
    if (reg_we) begin
      if (q_reg.size() == 0) check("reg_we_unexpected", reg_we, 0);
      else begin
        re = q_reg.pop_front();
        check("reg_we_cycle", cyc, re.cyc);
        check("wb_sel", wb_sel, re.wb_sel);
        check("rdest_sel", rdest_sel, re.rdest);
        check("rsrc_sel", rsrc_sel, re.rsrc);
        check("alu_op", alu_op, re.alu_op);
      end
    end
    if (flag_we) begin
      if (q_flag.size() == 0) check("flag_we_unexpected", flag_we, 0);
      else begin
        ce = q_flag.pop_front();
        check("flag_we_cycle", cyc, ce);
      end
    end
    if (illegal) begin
      if (q_ill.size() == 0) check("illegal_unexpected", illegal, 0);
      else begin
        ce = q_ill.pop_front();
        check("illegal_cycle", cyc, ce);
      end
    end
    if (mem_req) begin
      if (mem_run == 0) mem_we_first = mem_we;
      else check("mem_we_stable", mem_we, mem_we_first);
      mem_run++;
    end else if (mem_run > 0) begin
      if (q_mem.size() == 0) check("mem_req_unexpected", mem_run, 0);
      else begin
        me = q_mem.pop_front();
        check("mem_req_len", mem_run, me.len);
        check("mem_we", mem_we_first, me.we);
      end
      mem_run = 0;
    end
    if (!rst) prev_ret = 0;
    else if (int'(retired) != prev_ret) begin
      if (q_ret.size() == 0) check("retired_unexpected", retired, prev_ret);
      else begin
        rt = q_ret.pop_front();
        check("retired_val", retired, rt.val);
        check("retired_cycle", cyc, rt.cyc);
      end
      prev_ret = int'(retired);
    end
  end

  task automatic issue(input logic [15:0] w, input bit hold, output int f);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fetch_ready_wait", instr_ready, 1);
    f = cyc;
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_reg_we"}, reg_we, 0);
    check({tag, "_flag_we"}, flag_we, 0);
    check({tag, "_wb_sel"}, wb_sel, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_mem_err"}, mem_err, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_rdest"}, rdest_sel, 0);
    check({tag, "_rsrc"}, rsrc_sel, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    #2 rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", instr_ready, 1);

    // ADD r2,r3 with instr_valid held through execution
    issue(16'h0253, 1'b1, f);
    q_flag.push_back(f + 2);
    q_reg.push_back('{f + 3, 1'b0, 4'd2, 4'd3, 4'd5});
    q_ret.push_back('{f + 4, 1});
    at_cyc(f + 3);
    instr_valid = 1'b0;
    at_cyc(f + 4);

    // CMP: flags only, back in FETCH on cycle 4
    issue(16'h01B3, 1'b0, f);
    q_flag.push_back(f + 2);
    q_ret.push_back('{f + 3, 2});
    at_cyc(f + 2);
    check("cmp_ready_exec", instr_ready, 0);
    at_cyc(f + 3);
    check("cmp_ready_next", instr_ready, 1);

    // LOAD with ack in the fourth MEM cycle
    issue(16'h4402, 1'b0, f);
    q_mem.push_back('{4, 1'b0});
    q_reg.push_back('{f + 6, 1'b1, 4'd4, 4'd2, 4'd0});
    q_ret.push_back('{f + 7, 3});
    repeat (4) @(posedge clk);
    #1 mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    at_cyc(f + 7);

    // STOR with no ack: times out after 15 MEM cycles
    issue(16'h4142, 1'b0, f);
    q_mem.push_back('{15, 1'b1});
    q_ret.push_back('{f + 17, 4});
    at_cyc(f + 16);
    check("stor_mem_err_before", mem_err, 0);
    check("stor_mem_req_last", mem_req, 1);
    at_cyc(f + 17);
    check("stor_mem_err_after", mem_err, 1);
    check("stor_mem_req_drop", mem_req, 0);
    check("stor_back_to_fetch", instr_ready, 1);

    // Illegal encoding behaves as a NOP
    issue(16'h0070, 1'b0, f);
    q_ill.push_back(f + 1);
    q_ret.push_back('{f + 2, 5});
    at_cyc(f + 2);
    check("illegal_one_pulse", illegal, 0);

    // HALT ignores further valid instructions
    issue(16'h0000, 1'b0, f);
    at_cyc(f + 2);
    check("halted_set", halted, 1);
    instr = 16'h0253;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_ready_low", instr_ready, 0);
      check("halt_stays", halted, 1);
    end
    instr_valid = 1'b0;
    check("halt_retired_frozen", retired, 5);

    // Reset out of HALT clears sticky status and counters
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("halt_rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Reset during the second MEM wait cycle of a LOAD
    issue(16'h4402, 1'b0, f);
    q_mem.push_back('{2, 1'b0});
    at_cyc(f + 3);
    check("load_mem_req_before_rst", mem_req, 1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("mem_rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("ready_after_mem_rst", instr_ready, 1);

    // Fetch resumes: ADD, then LOAD with ack in the first MEM cycle
    issue(16'h0253, 1'b0, f);
    q_flag.push_back(f + 2);
    q_reg.push_back('{f + 3, 1'b0, 4'd2, 4'd3, 4'd5});
    q_ret.push_back('{f + 4, 1});
    at_cyc(f + 4);

    issue(16'h4402, 1'b0, f);
    q_mem.push_back('{1, 1'b0});
    q_reg.push_back('{f + 3, 1'b1, 4'd4, 4'd2, 4'd0});
    q_ret.push_back('{f + 4, 2});
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b0;
    at_cyc(f + 5);

    repeat (3) @(negedge clk);
    check("pending_reg", q_reg.size(), 0);
    check("pending_flag", q_flag.size(), 0);
    check("pending_ill", q_ill.size(), 0);
    check("pending_mem", q_mem.size(), 0);
    check("pending_ret", q_ret.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
